// File: rtl/mem_io_bridge_if.sv
// Processor data-memory port as seen by the bridge, plus the block-RAM port it drives.
interface mem_io_bridge_if;
  logic [15:0] cpuAddr;
  logic        cpuWe;
  logic [15:0] cpuWdata;
  logic [15:0] cpuRdata;
  logic [15:0] ramAddr;
  logic        ramWe;
  logic [15:0] ramWdata;
  logic [15:0] ramRdata;

  modport master (
    output cpuAddr, cpuWe, cpuWdata, ramRdata,
    input  cpuRdata, ramAddr, ramWe, ramWdata
  );

  modport slave (
    input  cpuAddr, cpuWe, cpuWdata, ramRdata,
    output cpuRdata, ramAddr, ramWe, ramWdata
  );
endinterface

// File: rtl/mem_io_bridge.sv
// Decodes processor data accesses to block RAM or a page of memory-mapped I/O
// (LEDs, switches, button edge capture, prescaled timer) with 1-cycle read latency.
module mem_io_bridge #(
  parameter logic [15:0] IO_BASE   = 16'hFF00,
  parameter int unsigned LED_WIDTH = 10,
  parameter int unsigned SW_WIDTH  = 10,
  parameter int unsigned BTN_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_io_bridge_if.slave       bus,
  input  logic [SW_WIDTH-1:0]  sw,
  input  logic [BTN_WIDTH-1:0] btn,
  output logic [LED_WIDTH-1:0] led,
  output logic                 timerIrq
);

  typedef enum logic [7:0] {
    OFF_LED  = 8'h00,
    OFF_SW   = 8'h01,
    OFF_BTN  = 8'h02,
    OFF_CNT  = 8'h03,
    OFF_PRE  = 8'h04,
    OFF_CTRL = 8'h05
  } io_off_e;

  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [SW_WIDTH-1:0]  sw_s1_q, sw_s2_q;
  logic [BTN_WIDTH-1:0] btn_s1_q, btn_s2_q, btn_s3_q;
  logic [BTN_WIDTH-1:0] edge_q, edge_d;
  logic [15:0]          count_q, count_d;
  logic [15:0]          prescale_q, prescale_d;
  logic [15:0]          pre_cnt_q, pre_cnt_d;
  logic                 enable_q, enable_d;
  logic                 ovf_q, ovf_d;
  logic                 selIo_q;
  logic [15:0]          ioRdata_q, io_rd;

  logic    isIo, wr, tick;
  io_off_e off;

  assign isIo = (bus.cpuAddr[15:8] == IO_BASE[15:8]);
  assign off  = io_off_e'(bus.cpuAddr[7:0]);
  assign wr   = bus.cpuWe & isIo;
  assign tick = enable_q && (pre_cnt_q == prescale_q);

  assign bus.ramAddr  = bus.cpuAddr;
  assign bus.ramWe    = bus.cpuWe & ~isIo;
  assign bus.ramWdata = bus.cpuWdata;
  assign bus.cpuRdata = selIo_q ? ioRdata_q : bus.ramRdata;
  assign led          = led_q;
  assign timerIrq     = ovf_q;

  // Mux reads current register contents, so a same-cycle write is not visible yet.
  always_comb begin
    io_rd = '0;
    case (off)
      OFF_LED:  io_rd[LED_WIDTH-1:0] = led_q;
      OFF_SW:   io_rd[SW_WIDTH-1:0]  = sw_s2_q;
      OFF_BTN:  io_rd[BTN_WIDTH-1:0] = edge_q;
      OFF_CNT:  io_rd = count_q;
      OFF_PRE:  io_rd = prescale_q;
      OFF_CTRL: io_rd[1:0] = {ovf_q, enable_q};
      default:  io_rd = '0;
    endcase
  end

  always_comb begin
    led_d      = led_q;
    edge_d     = edge_q;
    count_d    = count_q;
    prescale_d = prescale_q;
    pre_cnt_d  = pre_cnt_q;
    enable_d   = enable_q;
    ovf_d      = ovf_q;

    if (wr && off == OFF_LED) led_d = bus.cpuWdata[LED_WIDTH-1:0];

    // New edges are OR-ed in after the W1C mask so a simultaneous set survives.
    if (wr && off == OFF_BTN) edge_d = edge_q & ~bus.cpuWdata[BTN_WIDTH-1:0];
    edge_d = edge_d | (btn_s2_q & ~btn_s3_q);

    if (wr && off == OFF_PRE) prescale_d = bus.cpuWdata;

    if (wr && off == OFF_PRE)  pre_cnt_d = '0;
    else if (enable_q)         pre_cnt_d = tick ? '0 : pre_cnt_q + 16'd1;

    if (wr && off == OFF_CNT)  count_d = bus.cpuWdata;
    else if (tick)             count_d = count_q + 16'd1;

    if (wr && off == OFF_CTRL) begin
      enable_d = bus.cpuWdata[0];
      if (bus.cpuWdata[2]) ovf_d = 1'b0;
    end
    if (tick && !(wr && off == OFF_CNT) && count_q == 16'hFFFF) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q      <= '0;
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      btn_s3_q   <= '0;
      edge_q     <= '0;
      count_q    <= '0;
      prescale_q <= '0;
      pre_cnt_q  <= '0;
      enable_q   <= 1'b0;
      ovf_q      <= 1'b0;
      selIo_q    <= 1'b1;
      ioRdata_q  <= '0;
    end else begin
      led_q      <= led_d;
      sw_s1_q    <= sw;
      sw_s2_q    <= sw_s1_q;
      btn_s1_q   <= btn;
      btn_s2_q   <= btn_s1_q;
      btn_s3_q   <= btn_s2_q;
      edge_q     <= edge_d;
      count_q    <= count_d;
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
      enable_q   <= enable_d;
      ovf_q      <= ovf_d;
      selIo_q    <= isIo;
      ioRdata_q  <= io_rd;
    end
  end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed and randomized checks of mem_io_bridge against a behavioural model.
module tb_mem_io_bridge;

  logic       clk;
  logic       rst_n;
  logic [9:0] sw;
  logic [3:0] btn;
  logic [9:0] led;
  logic       timerIrq;

  int unsigned tests = 0;
  int unsigned fails = 0;

  mem_io_bridge_if bus ();

  mem_io_bridge #(
    .IO_BASE  (16'hFF00),
    .LED_WIDTH(10),
    .SW_WIDTH (10),
    .BTN_WIDTH(4)
  ) dut (
    .clk     (clk),
    .reset   (rst_n),
    .bus     (bus),
    .sw      (sw),
    .btn     (btn),
    .led     (led),
    .timerIrq(timerIrq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous block-RAM stand-in behind the bridge.
  logic [15:0] ram [0:65535];
  always @(posedge clk) begin
    if (bus.ramWe) ram[bus.ramAddr] <= bus.ramWdata;
    bus.ramRdata <= ram[bus.ramAddr];
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    bus.cpuAddr = a;
    bus.cpuWe   = 1'b0;
    cyc();
    d = bus.cpuRdata;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] v, output logic [15:0] d);
    bus.cpuAddr  = a;
    bus.cpuWe    = 1'b1;
    bus.cpuWdata = v;
    cyc();
    d = bus.cpuRdata;
    bus.cpuWe = 1'b0;
  endtask

  initial begin
    logic [15:0] d, v, exp_led;
    logic [15:0] addrs[$];
    logic [15:0] exp_ram [logic [15:0]];
    logic [3:0]  m;
    int unsigned p, n;

    rst_n = 1'b0;
    sw = '0;
    btn = '0;
    bus.cpuAddr = 16'hFF00;
    bus.cpuWe = 1'b0;
    bus.cpuWdata = '0;

    // Reset state
    repeat (2) cyc();
    check("rst_rdata", bus.cpuRdata, 16'h0000);
    check("rst_led", {6'b0, led}, 16'h0000);
    check("rst_irq", {15'b0, timerIrq}, 16'h0000);
    rst_n = 1'b1;
    rd(16'hFF00, d); check("rd_led0", d, 16'h0000);
    rd(16'hFF03, d); check("rd_cnt0", d, 16'h0000);
    rd(16'hFF05, d); check("rd_ctrl0", d, 16'h0000);

    // RAM write/read and write-enable gating
    bus.cpuAddr = 16'h0010; bus.cpuWe = 1'b1; bus.cpuWdata = 16'h1234;
    #1;
    check("ramWe_wr", {15'b0, bus.ramWe}, 16'h0001);
    check("ramAddr", bus.ramAddr, 16'h0010);
    check("ramWdata", bus.ramWdata, 16'h1234);
    cyc();
    bus.cpuWe = 1'b0;
    #1;
    check("ramWe_idle", {15'b0, bus.ramWe}, 16'h0000);
    rd(16'h0010, d); check("ram_rd", d, 16'h1234);
    bus.cpuAddr = 16'hFF00; bus.cpuWe = 1'b1; bus.cpuWdata = 16'h00AA;
    #1;
    check("ramWe_io", {15'b0, bus.ramWe}, 16'h0000);
    cyc();
    bus.cpuWe = 1'b0;
    check("led_aa", {6'b0, led}, 16'h00AA);
    rd(16'hFF00, d); check("led_rd", d, 16'h00AA);
    exp_led = 16'h00AA;

    for (int i = 0; i < 8; i++) begin
      v = 16'($urandom_range(0, 16'hFEFF));
      addrs.push_back(v);
      exp_ram[v] = 16'($urandom);
      wr(v, exp_ram[v], d);
    end
    foreach (addrs[i]) begin
      rd(addrs[i], d);
      check("ram_rand", d, exp_ram[addrs[i]]);
    end

    for (int i = 0; i < 6; i++) begin
      v = 16'($urandom);
      wr(16'hFF00, v, d);
      check("led_rdw", d, exp_led);
      exp_led = {6'b0, v[9:0]};
      check("led_out", {6'b0, led}, exp_led);
      rd(16'hFF00, d); check("led_rand_rd", d, exp_led);
    end

    // Switch synchronizer
    sw = 10'h155;
    rd(16'hFF01, d); check("sw_sync1", d, 16'h0000);
    rd(16'hFF01, d); check("sw_sync2", d, 16'h0000);
    rd(16'hFF01, d); check("sw_sync3", d, 16'h0155);
    for (int i = 0; i < 4; i++) begin
      v = 16'($urandom_range(0, 1023));
      sw = v[9:0];
      cyc(); cyc();
      rd(16'hFF01, d); check("sw_rand", d, v);
    end
    wr(16'hFF01, 16'hFFFF, d);
    rd(16'hFF01, d); check("sw_ro", d, v);

    // Button edge capture
    btn = 4'h4;
    repeat (5) cyc();
    btn = 4'h0;
    repeat (3) cyc();
    rd(16'hFF02, d); check("btn_edge", d, 16'h0004);
    btn = 4'h4;
    cyc(); cyc();
    wr(16'hFF02, 16'h0004, d);
    rd(16'hFF02, d); check("btn_setwins", d, 16'h0004);
    wr(16'hFF02, 16'h0004, d);
    rd(16'hFF02, d); check("btn_w1c", d, 16'h0000);
    btn = 4'h0;
    repeat (3) cyc();
    rd(16'hFF02, d); check("btn_fall", d, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      m = 4'($urandom_range(1, 15));
      btn = m;
      repeat (4) cyc();
      rd(16'hFF02, d); check("btn_rand", d, {12'b0, m});
      wr(16'hFF02, {12'b0, m}, d);
      btn = 4'h0;
      repeat (3) cyc();
      rd(16'hFF02, d); check("btn_rand_clr", d, 16'h0000);
    end

    // Timer with prescale 3
    wr(16'hFF05, 16'h0000, d);
    wr(16'hFF03, 16'h0000, d);
    wr(16'hFF04, 16'h0003, d);
    wr(16'hFF05, 16'h0001, d);
    repeat (40) cyc();
    rd(16'hFF03, d); check("tmr_40", d, 16'd10);
    wr(16'hFF05, 16'h0000, d);
    repeat (10) cyc();
    rd(16'hFF03, d); check("tmr_hold", d, 16'd42 / 16'd4);

    v = 16'($urandom);
    wr(16'hFF04, v, d);
    rd(16'hFF04, d); check("pre_rd", d, v);

    for (int i = 0; i < 6; i++) begin
      p = $urandom_range(0, 7);
      n = $urandom_range(5, 60);
      wr(16'hFF03, 16'h0000, d);
      wr(16'hFF04, 16'(p), d);
      wr(16'hFF05, 16'h0001, d);
      repeat (n) cyc();
      rd(16'hFF03, d); check("tmr_rand", d, 16'(n / (p + 1)));
      wr(16'hFF05, 16'h0000, d);
    end

    // Overflow, clear, write-vs-tick
    wr(16'hFF04, 16'h0000, d);
    wr(16'hFF03, 16'hFFFE, d);
    wr(16'hFF05, 16'h0001, d);
    cyc(); cyc();
    check("ovf_irq", {15'b0, timerIrq}, 16'h0001);
    rd(16'hFF03, d); check("ovf_cnt", d, 16'h0000);
    rd(16'hFF05, d); check("ovf_stat", d, 16'h0003);
    wr(16'hFF05, 16'h0005, d); check("ctrl_rdw", d, 16'h0003);
    check("ovf_clr_irq", {15'b0, timerIrq}, 16'h0000);
    rd(16'hFF05, d); check("ovf_clr_stat", d, 16'h0001);
    wr(16'hFF03, 16'hFFFF, d);
    wr(16'hFF03, 16'h1234, d);
    check("wr_vs_wrap_irq", {15'b0, timerIrq}, 16'h0000);
    rd(16'hFF03, d); check("wr_vs_wrap_cnt", d, 16'h1234);
    wr(16'hFF03, 16'hFFFF, d);
    wr(16'hFF05, 16'h0005, d);
    check("ovf_setwins", {15'b0, timerIrq}, 16'h0001);

    // Asynchronous reset mid-operation
    wr(16'hFF00, 16'h03FF, d);
    rd(16'hFF00, d); check("led_3ff", d, 16'h03FF);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_led", {6'b0, led}, 16'h0000);
    check("arst_irq", {15'b0, timerIrq}, 16'h0000);
    check("arst_rdata", bus.cpuRdata, 16'h0000);
    cyc();
    rst_n = 1'b1;
    rd(16'hFF06, d); check("rd_ff06", d, 16'h0000);
    rd(16'hFFFF, d); check("rd_ffff", d, 16'h0000);
    rd(16'hFF03, d); check("post_cnt", d, 16'h0000);
    rd(16'hFF05, d); check("post_ctrl", d, 16'h0000);
    wr(16'hFF06, 16'hBEEF, d);
    rd(16'hFF06, d); check("wr_ff06", d, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_io_bridge.md
Name: mem_io_bridge

Overview:
- Sits directly downstream of the processor's data-memory port.
- Takes the processor's address, write strobe and write data, and decodes each access to either the block-RAM data port or a small bank of memory-mapped I/O registers: LEDs, switches, button edge-capture and a prescaled timer.
- Returns read data on the processor's inbound data bus with a fixed 1-cycle latency for both targets, matching synchronous block-RAM read timing.

Parameters:
IO_BASE, 16'hFF00, base of the I/O page; an access is I/O when addr[15:8] == IO_BASE[15:8].
LED_WIDTH, 10, number of LED outputs.
SW_WIDTH, 10, number of switch inputs.
BTN_WIDTH, 4, number of pushbutton inputs.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
cpuAddr  input  16  processor data address
cpuWe  input  1  processor write strobe, one-cycle
cpuWdata  input  16  processor write data
cpuRdata  output  16  read data to processor, valid the cycle after the address
ramAddr  output  16  block-RAM address, equals cpuAddr combinationally
ramWe  output  1  block-RAM write enable
ramWdata  output  16  equals cpuWdata
ramRdata  input  16  block-RAM synchronous read data, 1-cycle latency
sw  input  SW_WIDTH  raw asynchronous switches
btn  input  BTN_WIDTH  raw asynchronous buttons, active-high
led  output  LED_WIDTH  LED register
timerIrq  output  1  level copy of timer overflow sticky bit

Behaviour:
- Reset values (reset low, asynchronous):
  - led=0, edge register=0, timer count=0, prescale reg=0, prescale counter=0.
  - enable=0, ovf=0, synchronizer flops=0.
  - selIo_q=1, ioRdata_q=0, so cpuRdata=0.
- Decode: isIo = (cpuAddr[15:8] == IO_BASE[15:8]).
  - ramWe = cpuWe & ~isIo; I/O addresses never write RAM.
- I/O register map (offset = cpuAddr[7:0]):
  - 0x00 LED: R/W; write loads led <= cpuWdata[LED_WIDTH-1:0]; read zero-extends.
  - 0x01 SW: RO; 2-flop synchronized sw, zero-extended; writes ignored.
  - 0x02 BTN_EDGE: W1C.
    - Bit i sets on the rising edge of the synchronized btn[i]; edge detection uses a third flop.
    - Writing 1 to bit i clears it.
    - Set wins over a simultaneous clear.
  - 0x03 TIMER_COUNT: R/W; a write loads the count.
  - 0x04 PRESCALE: R/W 16-bit.
  - 0x05 CTRL/STATUS: bit0 enable (R/W); bit1 ovf (RO); writing bit2=1 clears ovf; other bits read 0.
  - 0x06–0xFF: read 0, writes ignored.
- Read path:
  - Each cycle, selIo_q <= isIo and ioRdata_q <= I/O mux(cpuAddr) sampled that cycle.
  - cpuRdata = selIo_q ? ioRdata_q : ramRdata.
  - Latency is exactly 1 cycle for both targets.
  - Read-during-write to the same I/O register returns the pre-write value.
- Timer:
  - When enable=1, the prescale counter increments each cycle. When it equals PRESCALE, it resets to 0 and count increments, so count ticks every PRESCALE+1 cycles; PRESCALE=0 means every cycle.
  - Count wraps 0xFFFF→0x0000 and sets ovf.
  - A CPU write to TIMER_COUNT in the same cycle as a tick: the written value wins and ovf is not set by that tick.
  - A write to PRESCALE resets the prescale counter to 0.
  - enable=0 freezes both counters.
  - ovf set and clear in the same cycle: set wins.
- timerIrq = ovf.
- Reset mid-operation clears all state immediately; a pending read returns 0 on the next cycle.

Test Plan:
1. Reset low, then release; read 0xFF00, 0xFF03, 0xFF05 -> cpuRdata = 0x0000 each, one cycle after the address; led=0, timerIrq=0.
2. Write 0x1234 to 0x0010, then read 0x0010 -> ramWe=1 on the write cycle only; cpuRdata=0x1234 one cycle after the read address. Write 0x00AA to 0xFF00 -> ramWe stays 0, led=0x0AA; read-back returns 0x00AA.
3. Set sw=10'h155 -> a read of 0xFF01 returns 0x0155 only once 2 synchronizer cycles have elapsed. Pulse btn[2] high for 5 cycles -> 0xFF02 reads 0x0004. Write 0x0004 in the same cycle as a new btn[2] edge -> bit stays 1. A later write of 0x0004 -> reads 0x0000.
4. PRESCALE=3, CTRL=0x0001 -> TIMER_COUNT increments every 4 cycles; after 40 cycles it reads 10. Clear enable -> the value holds.
5. Write TIMER_COUNT=0xFFFE with PRESCALE=0, enable=1 -> after 2 ticks count=0x0000, ovf=1, timerIrq=1. Write CTRL=0x0005 -> ovf=0, enable stays 1. Write count in the same cycle as a wrap -> written value loaded, ovf unchanged.
6. Assert reset while the timer runs and led=0x3FF -> all outputs 0 asynchronously, before the next clk edge; reads of 0xFF06 and 0xFFFF return 0x0000.
